rpn_stack_calc: RTL and testbench

//  Parametrised bit-serial RPN calculator: WIDTH-bit operands, DEPTH-entry LIFO, 8 opcodes.

---
 rtl/rpn_pkg.sv | 24 ++
 rtl/rpn_stack_calc_if.sv | 17 +
 rtl/rpn_serializer.sv | 58 +++++
 rtl/rpn_stack_calc.sv | 199 +++++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// Shared encodings for the bit-serial RPN calculator: opcodes, frame kinds, FSM states.
package rpn_pkg;

  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_ENTER = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_DROP  = 3'b111;

  localparam logic KIND_PUSH = 1'b0;
  localparam logic KIND_OP   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KIND = 3'd1,
    ST_DATA = 3'd2,
    ST_OP   = 3'd3,
    ST_EXEC = 3'd4
  } state_e;

endpackage

// File: rtl/rpn_stack_calc_if.sv
// Serial command/result link and status lines of the RPN calculator.
interface rpn_stack_calc_if #(
  parameter int DEPTH = 8
);
  localparam int PW = $clog2(DEPTH + 1);

  logic          dIn;
  logic          dOut;
  logic          overflow;
  logic          underflow;
  logic          busy;
  logic [PW-1:0] depth_cnt;

  modport master (output dIn, input dOut, overflow, underflow, busy, depth_cnt);
  modport slave  (input dIn, output dOut, overflow, underflow, busy, depth_cnt);

endinterface

// File: rtl/rpn_serializer.sv
// Result transmitter: one start bit (1) then WIDTH data bits MSB first; busy covers all WIDTH+1 cycles.
module rpn_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             dout_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    busy_d = busy_q;
    if (load_i) begin
      sh_d   = data_i;
      cnt_d  = CW'(WIDTH);
      dout_d = 1'b1;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        dout_d = 1'b0;
      end else begin
        dout_d = sh_q[WIDTH-1];
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
    end
  end

  assign dout_o = dout_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/rpn_stack_calc.sv
// Bit-serial RPN calculator: frame FSM, shift-in register, LIFO stack and ALU.
// Define RPN_SATURATE_EN to make ADD/MUL clamp at all-ones and SUB clamp at zero.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  rpn_stack_calc_if.slave  bus
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH + 1);
  // Shift register must hold at least the 3 opcode bits even for tiny WIDTH.
  localparam int SW = (WIDTH < 3) ? 3 : WIDTH;

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             kind_q, kind_d;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [AW-1:0]    tos_idx, nos_idx, push_idx;
  logic [WIDTH-1:0] tos, nos;
  logic [WIDTH-1:0] add_res, mul_res, sub_res, alu_res;
  logic             ser_load, ser_busy, ser_dout;
  logic [2:0]       opcode;

  // Frame receiver
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    kind_d    = kind_q;
    case (state_q)
      ST_IDLE: if (bus.dIn) state_d = ST_KIND;
      ST_KIND: begin
        kind_d = bus.dIn;
        if (bus.dIn == KIND_OP) begin
          state_d   = ST_OP;
          bit_cnt_d = BW'(3);
        end else begin
          state_d   = ST_DATA;
          bit_cnt_d = BW'(WIDTH);
        end
      end
      ST_DATA, ST_OP: begin
        shift_d   = {shift_q[SW-2:0], bus.dIn};
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == BW'(1)) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      kind_q    <= KIND_PUSH;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      kind_q    <= kind_d;
    end
  end

  assign tos_idx  = AW'(sp_q - PW'(1));
  assign nos_idx  = AW'(sp_q - PW'(2));
  assign push_idx = AW'(sp_q);
  assign tos      = stack_q[tos_idx];
  assign nos      = stack_q[nos_idx];
  assign opcode   = shift_q[2:0];

`ifdef RPN_SATURATE_EN
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] prod_w;
  assign sum_w   = {1'b0, nos} + {1'b0, tos};
  assign diff_w  = {1'b0, nos} - {1'b0, tos};
  assign prod_w  = {{WIDTH{1'b0}}, nos} * {{WIDTH{1'b0}}, tos};
  assign add_res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
  assign sub_res = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
  assign mul_res = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
`else
  assign add_res = nos + tos;
  assign sub_res = nos - tos;
  assign mul_res = nos * tos;
`endif

  always_comb begin
    alu_res = add_res;
    case (opcode)
      OP_MUL:  alu_res = mul_res;
      OP_SUB:  alu_res = sub_res;
      default: alu_res = add_res;
    endcase
  end

  // Stack execution; exactly one frame is acted on per EXEC cycle
  always_comb begin
    stack_d  = stack_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ser_load = 1'b0;
    if (state_q == ST_EXEC) begin
      if (kind_q == KIND_PUSH) begin
        if (sp_q == PW'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          stack_d[push_idx] = shift_q[WIDTH-1:0];
          sp_d              = sp_q + PW'(1);
        end
      end else begin
        case (opcode)
          OP_CLEAR: begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
          OP_ADD, OP_MUL, OP_SUB: begin
            if (sp_q < PW'(2)) begin
              unf_d = 1'b1;
            end else begin
              stack_d[nos_idx] = alu_res;
              sp_d             = sp_q - PW'(1);
            end
          end
          OP_ENTER: begin
            if (sp_q == '0) unf_d = 1'b1;
            else if (!ser_busy) ser_load = 1'b1;
          end
          OP_DUP: begin
            if (sp_q == '0) begin
              unf_d = 1'b1;
            end else if (sp_q == PW'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              stack_d[push_idx] = tos;
              sp_d              = sp_q + PW'(1);
            end
          end
          OP_SWAP: begin
            if (sp_q < PW'(2)) begin
              unf_d = 1'b1;
            end else begin
              stack_d[tos_idx] = nos;
              stack_d[nos_idx] = tos;
            end
          end
          default: begin
            if (sp_q == '0) unf_d = 1'b1;
            else            sp_d  = sp_q - PW'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      stack_q <= stack_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  rpn_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (ser_load),
    .data_i (tos),
    .dout_o (ser_dout),
    .busy_o (ser_busy)
  );

  assign bus.dOut      = ser_dout;
  assign bus.busy      = ser_busy;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.depth_cnt = sp_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc (WIDTH=8, DEPTH=8); hand-computed expectations, RPN_SATURATE_EN aware.
module tb_rpn_stack_calc;
  import rpn_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 12;
`ifdef RPN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rpn_stack_calc_if #(.DEPTH(DEPTH)) bus();

  rpn_stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1 bus.dIn = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_push(input logic [WIDTH-1:0] v);
    drive_bit(1'b1);
    drive_bit(KIND_PUSH);
    for (int i = WIDTH - 1; i >= 0; i--) drive_bit(v[i]);
    drive_bit(1'b0);
  endtask

  task automatic send_op(input logic [2:0] op);
    drive_bit(1'b1);
    drive_bit(KIND_OP);
    for (int i = 2; i >= 0; i--) drive_bit(op[i]);
    drive_bit(1'b0);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] v);
    send_push(v);
    idle(GAP);
  endtask

  task automatic do_op(input logic [2:0] op);
    send_op(op);
    idle(GAP);
  endtask

  // Send ENTER, capture the result frame and compare it with exp.
  task automatic enter_expect(input string tag, input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] v;
    bit seen;
    bit busy_all;
    seen     = 1'b0;
    busy_all = 1'b1;
    v        = '0;
    send_op(OP_ENTER);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dOut) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_start"}, 32'(seen), 32'd1);
    if (seen) begin
      busy_all &= bus.busy;
      for (int i = 0; i < WIDTH; i++) begin
        @(negedge clk);
        v = {v[WIDTH-2:0], bus.dOut};
        busy_all &= bus.busy;
      end
      check({tag, "_busy"}, 32'(busy_all), 32'd1);
      check(tag, 32'(v), 32'(exp));
      @(negedge clk);
      check({tag, "_end"}, {30'd0, bus.busy, bus.dOut}, 32'd0);
    end
    idle(GAP);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.dOut || bus.busy) act++;
    end
    check(tag, act, 0);
  endtask

  initial begin
    bit seen;
    bus.dIn = 1'b0;
    rst     = 1'b1;
    idle(3);
    #1;
    check("rst_dOut", 32'(bus.dOut), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_depth", 32'(bus.depth_cnt), 32'd0);
    check("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    for (int i = 1; i <= 5; i++) do_push(WIDTH'(i));
    check("depth_5", 32'(bus.depth_cnt), 32'd5);
    enter_expect("enter_5", 8'd5);
    check("depth_after_enter", 32'(bus.depth_cnt), 32'd5);
    do_op(OP_ADD);
    enter_expect("add_9", 8'd9);
    do_op(OP_MUL);
    enter_expect("mul_27", 8'd27);
    check("depth_3", 32'(bus.depth_cnt), 32'd3);

    do_op(OP_CLEAR);
    check("clear_depth", 32'(bus.depth_cnt), 32'd0);
    do_push(8'd254);
    do_push(8'd1);
    do_op(OP_ADD);
    enter_expect("add_255", 8'd255);
    do_push(8'd1);
    do_op(OP_ADD);
    enter_expect("add_wrap", SAT ? 8'd255 : 8'd0);
    check("depth_1", 32'(bus.depth_cnt), 32'd1);

    do_push(8'd10);
    do_push(8'd3);
    do_op(OP_SUB);
    enter_expect("sub_7", 8'd7);
    do_push(8'd5);
    do_op(OP_SWAP);
    do_op(OP_SUB);
    enter_expect("sub_wrap", SAT ? 8'd0 : 8'd254);
    check("depth_2", 32'(bus.depth_cnt), 32'd2);
    do_op(OP_DROP);
    check("drop_depth", 32'(bus.depth_cnt), 32'd1);
    enter_expect("drop_tos", SAT ? 8'd255 : 8'd0);
    check("no_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);

    do_op(OP_CLEAR);
    for (int i = 0; i < 8; i++) do_push(WIDTH'(11 + i));
    check("full_no_ovf", 32'(bus.overflow), 32'd0);
    do_push(8'd19);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_depth", 32'(bus.depth_cnt), 32'd8);
    enter_expect("ovf_tos", 8'd18);
    do_op(OP_DUP);
    check("dup_full_depth", 32'(bus.depth_cnt), 32'd8);
    check("ovf_no_unf", 32'(bus.underflow), 32'd0);
    do_op(OP_CLEAR);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    check("ovf_clr_depth", 32'(bus.depth_cnt), 32'd0);

    do_op(OP_ADD);
    check("unf_add", 32'(bus.underflow), 32'd1);
    do_op(OP_DROP);
    send_op(OP_ENTER);
    expect_quiet("unf_quiet", 16);
    check("unf_depth", 32'(bus.depth_cnt), 32'd0);
    check("unf_sticky", 32'(bus.underflow), 32'd1);
    do_op(OP_CLEAR);
    check("unf_cleared", 32'(bus.underflow), 32'd0);

    do_push(8'd7);
    do_op(OP_DUP);
    do_op(OP_MUL);
    check("dup_mul_depth", 32'(bus.depth_cnt), 32'd1);
    send_op(OP_ENTER);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dOut) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_tx_start", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_tx_busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_tx_dOut", 32'(bus.dOut), 32'd0);
    check("rst_tx_busy0", 32'(bus.busy), 32'd0);
    check("rst_tx_depth", 32'(bus.depth_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    do_push(8'd42);
    enter_expect("post_rst", 8'd42);
    check("post_rst_depth", 32'(bus.depth_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
